// File: rtl/axil_cmd_sequencer.sv
// AXI4-Lite single-beat command sequencer.
// Accepts one local command at a time and runs it as a write (AW+W, then B)
// or a read (AR, then R) on an AXI4-Lite slave. A per-state wait counter
// aborts a stalled handshake and reports it as an error response.

module axil_cmd_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              ARESETN,
   // local command side
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   // AXI4-Lite write channels
   output logic [ADDR_W-1:0] AWADDR,
   output logic              AWVALID,
   input  logic              AWREADY,
   output logic [DATA_W-1:0] WDATA,
   output logic              WVALID,
   input  logic              WREADY,
   input  logic              BVALID,
   input  logic [1:0]        BRESP,
   output logic              BREADY,
   // AXI4-Lite read channels
   output logic [ADDR_W-1:0] ARADDR,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic              RVALID,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   output logic              RREADY
);

   // state    | meaning
   // ---------+-----------------------------------------------------------
   // S_IDLE   | cmd_ready high, waiting for a command
   // S_WR_AW  | AWVALID/WVALID outstanding, each drops on its own READY
   // S_WR_B   | BREADY high, waiting for the write response
   // S_RD_AR  | ARVALID outstanding
   // S_RD_R   | RREADY high, waiting for read data
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR_AW = 3'd1,
      S_WR_B  = 3'd2,
      S_RD_AR = 3'd3,
      S_RD_R  = 3'd4
   } state_t;

   // Counter only needs to reach TIMEOUT-1: the abort fires on the edge that
   // would have taken it to TIMEOUT.
   localparam int               CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int               CNT_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CNT_LAST_I);
   localparam bit               TIMEOUT_EN = (TIMEOUT > 0);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
   logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
   logic                awvalid_q, awvalid_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                wvalid_q, wvalid_d;
   logic                bready_q, bready_d;
   logic [ADDR_W-1:0]   araddr_q, araddr_d;
   logic                arvalid_q, arvalid_d;
   logic                rready_q, rready_d;

   logic [ADDR_W-1:0]   addr_aligned;
   logic [1:0]          unused_addr_lsb;
   logic                timeout_hit;
   logic                aw_pend;
   logic                w_pend;

   // Byte-address LSBs are dropped; transfers are always word aligned.
   assign addr_aligned    = {cmd_addr[ADDR_W-1:2], 2'b00};
   assign unused_addr_lsb = cmd_addr[1:0];

   assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);
   assign aw_pend     = awvalid_q & ~AWREADY;
   assign w_pend      = wvalid_q & ~WREADY;

   // Next-state and next-output logic; a handshake wins over a same-cycle timeout.
   always_comb begin
      logic abort;
      abort       = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      awaddr_d    = awaddr_q;
      awvalid_d   = awvalid_q;
      wdata_d     = wdata_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      araddr_d    = araddr_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;

      case (state_q)
         S_IDLE: begin
            cnt_d       = '0;
            cmd_ready_d = 1'b1;
            if (cmd_ready_q && cmd_valid) begin
               cmd_ready_d = 1'b0;
               if (cmd_write) begin
                  awaddr_d  = addr_aligned;
                  wdata_d   = cmd_wdata;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WR_AW;
               end else begin
                  araddr_d  = addr_aligned;
                  arvalid_d = 1'b1;
                  state_d   = S_RD_AR;
               end
            end
         end
         S_WR_AW: begin
            awvalid_d = aw_pend;
            wvalid_d  = w_pend;
            cnt_d     = cnt_q + CNT_W'(1);
            if (!aw_pend && !w_pend) begin
               bready_d = 1'b1;
               cnt_d    = '0;
               state_d  = S_WR_B;
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end
         S_WR_B: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (BVALID) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = (BRESP != 2'b00);
               cmd_ready_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end
         S_RD_AR: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               cnt_d     = '0;
               state_d   = S_RD_R;
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end
         S_RD_R: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (RVALID) begin
               rready_d    = 1'b0;
               rsp_rdata_d = RDATA;
               rsp_valid_d = 1'b1;
               rsp_err_d   = (RRESP != 2'b00);
               cmd_ready_d = 1'b1;
               cnt_d       = '0;
               state_d     = S_IDLE;
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Stalled slave: withdraw every handshake and report an error.
      if (abort) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b1;
         cmd_ready_d = 1'b1;
         cnt_d       = '0;
         state_d     = S_IDLE;
      end
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clk or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         awaddr_q    <= '0;
         awvalid_q   <= 1'b0;
         wdata_q     <= '0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         araddr_q    <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         awaddr_q    <= awaddr_d;
         awvalid_q   <= awvalid_d;
         wdata_q     <= wdata_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         araddr_q    <= araddr_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign AWADDR    = awaddr_q;
   assign AWVALID   = awvalid_q;
   assign WDATA     = wdata_q;
   assign WVALID    = wvalid_q;
   assign BREADY    = bready_q;
   assign ARADDR    = araddr_q;
   assign ARVALID   = arvalid_q;
   assign RREADY    = rready_q;

endmodule
